// File: rtl/irs3_reg_loader.sv
// Serial loader for the IRS3 configuration register: snapshots 13 shadow fields into a
// 145-bit frame and bit-bangs it MSB first. Optional readback check under IRS3_READBACK_EN.
module irs3_reg_loader #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic        SCLK,
  input  logic        TSTCLR,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_dat,
  input  logic        start,
  input  logic        start_clr,
  input  logic        irs_shout,
  output logic        irs_sin,
  output logic        irs_sclk,
  output logic        irs_pclk,
  output logic        irs_regclr,
  output logic        busy,
  output logic        done,
  output logic        rb_valid,
  output logic        rb_ok
);

  localparam int unsigned FRAME_W = 145;
  localparam int unsigned NFIELD  = 13;
  localparam int unsigned DIV_W   = 9;
  localparam int unsigned BIT_W   = 8;
  localparam logic [DIV_W-1:0] PH_LAST   = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] LONG_LAST = DIV_W'(2 * CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_snap;
  logic               sgn_q;
  logic [11:0]        field_q [1:NFIELD-1];
  logic               sin_d, sclk_d, pclk_d, regclr_d, busy_d, done_d;

  // Shadow fields; writable at any time, only sampled into the frame on an accepted start
  always_ff @(posedge SCLK or posedge TSTCLR) begin
    if (TSTCLR) begin
      sgn_q <= 1'b0;
      for (int i = 1; i < NFIELD; i++) field_q[i] <= '0;
    end else if (wr_en && (wr_addr < 4'(NFIELD))) begin
      if (wr_addr == 4'd0) sgn_q <= wr_dat[0];
      else                 field_q[wr_addr] <= wr_dat;
    end
  end

  // Field a (1..12) occupies frame bits [12a:12a-11]
  always_comb begin
    frame_snap[0] = sgn_q;
    for (int a = 1; a < NFIELD; a++) frame_snap[12*a-11 +: 12] = field_q[a];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = start_clr ? CLR : SHIFT_LO;
          div_d   = '0;
          bit_d   = BIT_TOP;
          frame_d = frame_snap;
        end
      end
      CLR: begin
        if (div_q == LONG_LAST) begin
          state_d = SHIFT_LO;
          div_d   = '0;
        end else div_d = div_q + 1'b1;
      end
      SHIFT_LO: begin
        if (div_q == PH_LAST) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else div_d = div_q + 1'b1;
      end
      SHIFT_HI: begin
        if (div_q == PH_LAST) begin
          div_d = '0;
          if (bit_q == '0) state_d = LATCH;
          else begin
            state_d = SHIFT_LO;
            bit_d   = bit_q - 8'd1;
          end
        end else div_d = div_q + 1'b1;
      end
      LATCH: begin
        if (div_q == LONG_LAST) begin
          state_d = DONE;
          div_d   = '0;
        end else div_d = div_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    sclk_d   = (state_d == SHIFT_HI);
    pclk_d   = (state_d == LATCH);
    regclr_d = (state_d == CLR);
    sin_d    = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? frame_d[bit_d] : 1'b0;
  end

  always_ff @(posedge SCLK or posedge TSTCLR) begin
    if (TSTCLR) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      irs_sin    <= 1'b0;
      irs_sclk   <= 1'b0;
      irs_pclk   <= 1'b0;
      irs_regclr <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      irs_sin    <= sin_d;
      irs_sclk   <= sclk_d;
      irs_pclk   <= pclk_d;
      irs_regclr <= regclr_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

`ifdef IRS3_READBACK_EN
  logic [FRAME_W-1:0] capture_q, expected_q;
  logic               clr_q;
  logic               sclk_rise;

  // SHOUT is sampled on the same edge that drives irs_sclk high, i.e. before the chip shifts
  assign sclk_rise = (state_q == SHIFT_LO) && (state_d == SHIFT_HI);

  always_ff @(posedge SCLK or posedge TSTCLR) begin
    if (TSTCLR) begin
      capture_q  <= '0;
      expected_q <= '0;
      clr_q      <= 1'b0;
      rb_valid   <= 1'b0;
      rb_ok      <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        rb_valid <= 1'b0;
        clr_q    <= start_clr;
      end
      if (sclk_rise) capture_q[bit_q] <= irs_shout;
      if (state_d == DONE) begin
        rb_valid   <= 1'b1;
        rb_ok      <= (capture_q == (clr_q ? FRAME_W'(0) : expected_q));
        expected_q <= frame_q;
      end
    end
  end
`else
  logic unused_shout;
  assign unused_shout = irs_shout;
  assign rb_valid     = 1'b0;
  assign rb_ok        = 1'b0;
`endif

endmodule

// File: tb/tb_irs3_reg_loader.sv
// Scoreboarded bench for irs3_reg_loader with a behavioural IRS3 chip model on the serial pins.
module tb_irs3_reg_loader;
  localparam int unsigned CLKDIV = 4;
`ifdef IRS3_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  logic        SCLK = 1'b0, TSTCLR = 1'b1;
  logic        wr_en = 1'b0, start = 1'b0, start_clr = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_dat = '0;
  logic        irs_shout;
  logic        irs_sin, irs_sclk, irs_pclk, irs_regclr, busy, done, rb_valid, rb_ok;

  irs3_reg_loader #(.CLKDIV(CLKDIV)) dut (
    .SCLK(SCLK), .TSTCLR(TSTCLR), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .start(start), .start_clr(start_clr), .irs_shout(irs_shout),
    .irs_sin(irs_sin), .irs_sclk(irs_sclk), .irs_pclk(irs_pclk), .irs_regclr(irs_regclr),
    .busy(busy), .done(done), .rb_valid(rb_valid), .rb_ok(rb_ok)
  );

  always #5 SCLK = ~SCLK;

  // Chip model: shift on irs_sclk rise, latch on irs_pclk rise, REGCLR clears both.
  // Quirk: latched sgn=0 with TRGbias=0x800 forces SHOUT low.
  logic [144:0] chip_sr = '0, chip_lat = '0;
  logic         quirk;
  always @(posedge irs_sclk or posedge irs_regclr)
    if (irs_regclr) chip_sr <= '0; else chip_sr <= {chip_sr[143:0], irs_sin};
  always @(posedge irs_pclk or posedge irs_regclr)
    if (irs_regclr) chip_lat <= '0; else chip_lat <= chip_sr;
  assign quirk     = (chip_lat[0] == 1'b0) && (chip_lat[12:1] == 12'h800);
  assign irs_shout = chip_sr[144] & ~quirk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [144:0] act, input logic [144:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: shadow fields by address, frame assembled from named fields
  logic [11:0]  sh [13];
  logic [144:0] model_prev = '0, pending_frame;

  function automatic logic [144:0] model_frame();
    logic [11:0] th [8];
    for (int j = 0; j < 8; j++) th[7-j] = sh[3+j];
    return {sh[12], sh[11], th[0], th[1], th[2], th[3], th[4], th[5], th[6], th[7],
            sh[2], sh[1], sh[0][0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 13; i++) sh[i] = '0;
    model_prev = '0;
  endtask

  typedef struct {
    logic [144:0] frame;
    logic         clr;
    int           busy_len;
    logic         rb_ok;
  } exp_t;
  exp_t sbq[$];

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    @(negedge SCLK);
    wr_en = 1'b1; wr_addr = a; wr_dat = d;
    if (a == 4'd0) sh[0] = {11'b0, d[0]};
    else if (a <= 4'd12) sh[a] = d;
    @(negedge SCLK);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic clr);
    exp_t e;
    logic [144:0] cap;
    e.frame    = model_frame();
    e.clr      = clr;
    e.busy_len = 2 * CLKDIV * (146 + int'(clr)) + 1;
    cap        = (clr || quirk) ? '0 : chip_sr;
    e.rb_ok    = RB_EN && (cap == (clr ? 145'(0) : model_prev));
    pending_frame = e.frame;
    sbq.push_back(e);
    @(negedge SCLK);
    start = 1'b1; start_clr = clr;
    @(negedge SCLK);
    start = 1'b0; start_clr = 1'b0;
    chk("rb_valid_clr", rb_valid, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && busy; i++) @(negedge SCLK);
    chk("done_timeout", busy, 0);
    model_prev = pending_frame;
  endtask

  // Monitor: collects pin activity for each load and checks it against the queue at done
  logic in_load = 0, prev_sclk = 0, prev_pclk = 0;
  int busy_cnt, rises, sclk_hi, pclk_cnt, pclk_pulses, clr_cnt, clr_late;
  logic [144:0] sin_vec;
  exp_t me;
  always @(negedge SCLK) begin
    if (TSTCLR) begin
      in_load = 0; prev_sclk = 0; prev_pclk = 0;
    end else begin
      if (busy && !in_load) begin
        in_load = 1; busy_cnt = 0; rises = 0; sclk_hi = 0; pclk_cnt = 0;
        pclk_pulses = 0; clr_cnt = 0; clr_late = 0; sin_vec = '0;
      end
      if (in_load) begin
        if (busy) busy_cnt++;
        if (irs_sclk) sclk_hi++;
        if (irs_sclk && !prev_sclk) begin rises++; sin_vec = {sin_vec[143:0], irs_sin}; end
        if (irs_pclk) pclk_cnt++;
        if (irs_pclk && !prev_pclk) pclk_pulses++;
        if (irs_regclr) begin clr_cnt++; if (rises != 0) clr_late++; end
        if (done) begin
          if (sbq.size() == 0) chk("unexpected_load", 1, 0);
          else begin
            me = sbq.pop_front();
            chk("frame", sin_vec, me.frame);
            chk("sclk_rises", rises, 145);
            chk("sclk_high_cycles", sclk_hi, 145 * CLKDIV);
            chk("pclk_pulses", pclk_pulses, 1);
            chk("pclk_width", pclk_cnt, 2 * CLKDIV);
            chk("regclr_width", clr_cnt, me.clr ? 2 * CLKDIV : 0);
            chk("regclr_order", clr_late, 0);
            chk("busy_len", busy_cnt, me.busy_len);
            chk("chip_latch", chip_lat, me.frame);
            chk("rb_valid", rb_valid, RB_EN);
            chk("rb_ok", rb_ok, me.rb_ok);
          end
          in_load = 0;
        end
      end
      prev_sclk = irs_sclk; prev_pclk = irs_pclk;
    end
  end

  logic [144:0] saved_lat;
  logic [11:0]  tb_new;

  initial begin
    model_reset();
    repeat (3) @(negedge SCLK);
    chk("reset_outputs", {irs_sin, irs_sclk, irs_pclk, irs_regclr, busy, done, rb_valid, rb_ok}, 0);
    TSTCLR = 1'b0;

    // All-zero frame
    do_start(1'b0); wait_done();

    // SBbias MSB only: first transmitted bit
    wr(4'd12, 12'h800);
    do_start(1'b0); wait_done();
    chk("chip_sbbias", chip_lat[144:133], 12'h800);

    // REGCLR phase with TRGthresh[3]
    wr(4'd12, 12'h000);
    wr(4'd7, 12'hABC);
    do_start(1'b1); wait_done();
    chk("chip_thresh3", chip_lat[84:73], 12'hABC);

`ifdef IRS3_READBACK_EN
    // Same pattern twice reads back; quirk pattern then corrupts readback
    for (int a = 1; a <= 12; a++) wr(4'(a), 12'($urandom));
    wr(4'd0, 12'h001);
    do_start(1'b0); wait_done();
    do_start(1'b0); wait_done();
    chk("rb_repeat_ok", rb_ok, 1);
    wr(4'd0, 12'h000);
    wr(4'd1, 12'h800);
    do_start(1'b0); wait_done();
    do_start(1'b0); wait_done();
    chk("rb_quirk_bad", rb_ok, 0);
`endif

    // Start and TBbias write during a load: single load of the original snapshot
    wr(4'd2, 12'h123);
    do_start(1'b0);
    repeat (1070) @(negedge SCLK);
    tb_new = 12'h5A5;
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_dat = tb_new; sh[2] = tb_new;
    @(negedge SCLK);
    start = 1'b0; wr_en = 1'b0;
    wait_done();
    do_start(1'b0); wait_done();
    chk("chip_tbbias_new", chip_lat[24:13], 12'h5A5);

    // Reset in the middle of bit 70
    saved_lat = chip_lat;
    do_start(1'b0);
    repeat (594) @(negedge SCLK);
    #2 TSTCLR = 1'b1;
    #1 chk("abort_outputs", {irs_sin, irs_sclk, irs_pclk, irs_regclr, busy, done, rb_valid, rb_ok}, 0);
    void'(sbq.pop_back());
    model_reset();
    repeat (2) @(negedge SCLK);
    TSTCLR = 1'b0;
    repeat (20) @(negedge SCLK);
    chk("abort_no_latch", chip_lat, saved_lat);
    do_start(1'b0); wait_done();

    // Random fields, random clear, including writes to unused addresses
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 5; w++) wr(4'($urandom_range(0, 15)), 12'($urandom));
      do_start(1'($urandom_range(0, 1))); wait_done();
    end

    repeat (5) @(negedge SCLK);
    chk("pending_loads", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
